// File: rtl/axi_lite_pkg.sv
// axi_lite_pkg: shared response codes, master states and constants for the AXI4-Lite initiator
package axi_lite_pkg;
  typedef enum logic [1:0] {
    RESP_OKAY   = 2'd0,
    RESP_EXOKAY = 2'd1,
    RESP_SLVERR = 2'd2,
    RESP_DECERR = 2'd3
  } resp_e;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_WR_RESP,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_RESP
  } state_e;
  localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_DEAD;
  localparam logic [2:0]  PROT_DEFAULT  = 3'b000;
  function automatic logic busy(input state_e s);
    return s == ST_WRITE || s == ST_WR_RESP || s == ST_RD_ADDR || s == ST_RD_DATA;
  endfunction
endpackage

// File: rtl/axi_lite_watchdog.sv
// axi_lite_watchdog: counts enabled cycles since clear and flags expiry at TIMEOUT_CYCLES (0 = never)
// Ports: clk/rst_n clock and async active-low reset; clr restarts the count; en counts this cycle;
// expired is high in the enabled cycle whose count would reach TIMEOUT_CYCLES.
module axi_lite_watchdog #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int CW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);
  logic [CW-1:0] count_q, count_d;
  always_comb count_d = clr ? '0 : en ? count_q + CW'(1) : count_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else count_q <= count_d;
  end
  assign expired = TIMEOUT_CYCLES != 0 && en && count_q == LAST;
endmodule

// File: rtl/axi_lite_master.sv
// axi_lite_master: single-outstanding AXI4-Lite initiator driven by a valid/ready command/response port
// Ports: axi_aclk/axi_aresetn clock and async active-low reset; cmd_* command in (accepted on
// cmd_valid&&cmd_ready); rsp_* response out (held until rsp_ready); M_AXI_* AXI4-Lite master channels.
module axi_lite_master
  import axi_lite_pkg::*;
#(
  parameter int C_M_AXI_ADDR_WIDTH = 40,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES     = 1024
) (
  input  logic                            axi_aclk,
  input  logic                            axi_aresetn,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                      rsp_resp,
  output logic                            rsp_timeout,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);
  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int DW = C_M_AXI_DATA_WIDTH;
  localparam logic [AW-1:0] ADDR_MASK = ~AW'(3);
  state_e state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d, rsp_rdata_q, rsp_rdata_d;
  logic [DW/8-1:0] wstrb_q, wstrb_d;
  logic [1:0] rsp_resp_q, rsp_resp_d;
  logic cmd_ready_q, cmd_ready_d, awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic arvalid_q, arvalid_d, rready_q, rready_d, rsp_valid_q, rsp_valid_d, rsp_timeout_q, rsp_timeout_d;
  logic accept, expired;
  axi_lite_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wd (
    .clk     (axi_aclk),
    .rst_n   (axi_aresetn),
    .clr     (accept),
    .en      (busy(state_q)),
    .expired (expired)
  );
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    awvalid_d     = awvalid_q;
    wvalid_d      = wvalid_q;
    bready_d      = bready_q;
    arvalid_d     = arvalid_q;
    rready_d      = rready_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_resp_d    = rsp_resp_q;
    rsp_timeout_d = rsp_timeout_q;
    accept        = 1'b0;
    unique case (state_q)
      ST_IDLE: if (cmd_valid && cmd_ready_q) begin
        accept    = 1'b1;
        addr_d    = cmd_addr & ADDR_MASK;
        wdata_d   = cmd_wdata;
        wstrb_d   = cmd_wstrb;
        awvalid_d = cmd_write;
        wvalid_d  = cmd_write;
        arvalid_d = !cmd_write;
        state_d   = cmd_write ? ST_WRITE : ST_RD_ADDR;
      end
      ST_WRITE: begin
        // AW and W retire independently; move on once both are gone
        awvalid_d = awvalid_q && !M_AXI_AWREADY;
        wvalid_d  = wvalid_q && !M_AXI_WREADY;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = ST_WR_RESP;
        end
      end
      ST_WR_RESP: if (M_AXI_BVALID) begin
        bready_d      = 1'b0;
        rsp_valid_d   = 1'b1;
        rsp_rdata_d   = '0;
        rsp_resp_d    = M_AXI_BRESP;
        rsp_timeout_d = 1'b0;
        state_d       = ST_RESP;
      end
      ST_RD_ADDR: if (M_AXI_ARREADY) begin
        arvalid_d = 1'b0;
        rready_d  = 1'b1;
        state_d   = ST_RD_DATA;
      end
      ST_RD_DATA: if (M_AXI_RVALID) begin
        rready_d      = 1'b0;
        rsp_valid_d   = 1'b1;
        rsp_rdata_d   = M_AXI_RDATA;
        rsp_resp_d    = M_AXI_RRESP;
        rsp_timeout_d = 1'b0;
        state_d       = ST_RESP;
      end
      ST_RESP: if (rsp_ready) begin
        rsp_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // A transaction that completes this cycle beats the watchdog; otherwise abandon the slave
    if (expired && state_d == state_q) begin
      awvalid_d     = 1'b0;
      wvalid_d      = 1'b0;
      bready_d      = 1'b0;
      arvalid_d     = 1'b0;
      rready_d      = 1'b0;
      rsp_valid_d   = 1'b1;
      rsp_rdata_d   = DW'(TIMEOUT_RDATA);
      rsp_resp_d    = RESP_DECERR;
      rsp_timeout_d = 1'b1;
      state_d       = ST_RESP;
    end
    cmd_ready_d = state_d == ST_IDLE;
  end
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state_q       <= ST_IDLE;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      cmd_ready_q   <= 1'b0;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      bready_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_resp_q    <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      cmd_ready_q   <= cmd_ready_d;
      awvalid_q     <= awvalid_d;
      wvalid_q      <= wvalid_d;
      bready_q      <= bready_d;
      arvalid_q     <= arvalid_d;
      rready_q      <= rready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_resp_q    <= rsp_resp_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end
  assign cmd_ready     = cmd_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_resp      = rsp_resp_q;
  assign rsp_timeout   = rsp_timeout_q;
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWPROT  = PROT_DEFAULT;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = wstrb_q;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARPROT  = PROT_DEFAULT;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;
endmodule

// File: tb/tb_axi_lite_master.sv
// tb_axi_lite_master: directed self-checking bench against a 16-register AXI4-Lite slave model
module tb_axi_lite_master;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic cmd_valid = 1'b0, cmd_write = 1'b0, rsp_ready = 1'b1;
  logic [39:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0] cmd_wstrb = '0;
  logic cmd_ready, rsp_valid, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [1:0] rsp_resp;
  logic [39:0] awaddr, araddr;
  logic [2:0] awprot, arprot;
  logic awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0] wstrb;
  logic [1:0] bresp, rresp;
  int errors = 0, checks = 0, cyc = 0;
  int aw_delay = 0, w_delay = 0, r_delay = 0;
  logic ar_en = 1'b1;
  logic aw_have, w_have, ar_have;
  int aw_cnt, w_cnt, r_cnt;
  int aw_hs = 0, w_hs = 0, early_b = 0;
  logic [39:0] aw_a, ar_a;
  logic [31:0] w_d;
  logic [3:0] w_s;
  logic [31:0] regs [16];
  int acc, g_lat;
  logic [31:0] g_rdata;
  logic [1:0] g_resp;
  logic g_to;

  axi_lite_master #(.C_M_AXI_ADDR_WIDTH(40), .C_M_AXI_DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
    .axi_aclk(clk), .axi_aresetn(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .rsp_timeout(rsp_timeout),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
  );

  // slave: register 0 is a read-only ID, addresses >= 0x40 answer SLVERR
  assign awready = !aw_have && aw_cnt >= aw_delay;
  assign wready  = !w_have && w_cnt >= w_delay;
  assign bvalid  = aw_have && w_have;
  assign bresp   = aw_a < 40'h40 ? 2'b00 : 2'b10;
  assign arready = ar_en && !ar_have;
  assign rvalid  = ar_have && r_cnt >= r_delay;
  assign rresp   = ar_a < 40'h40 ? 2'b00 : 2'b10;
  assign rdata   = ar_a >= 40'h40 ? 32'h0 : ar_a[5:2] == 4'd0 ? 32'hDEADBEEF : regs[ar_a[5:2]];

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_have <= 0; w_have <= 0; ar_have <= 0;
      aw_cnt <= 0; w_cnt <= 0; r_cnt <= 0;
      aw_a <= '0; ar_a <= '0; w_d <= '0; w_s <= '0;
      for (int i = 0; i < 16; i++) regs[i] <= '0;
    end else begin
      if (awvalid && awready) begin aw_have <= 1; aw_a <= awaddr; aw_cnt <= 0; aw_hs <= aw_hs + 1; end
      else if (awvalid && !aw_have) aw_cnt <= aw_cnt + 1;
      if (wvalid && wready) begin w_have <= 1; w_d <= wdata; w_s <= wstrb; w_cnt <= 0; w_hs <= w_hs + 1; end
      else if (wvalid && !w_have) w_cnt <= w_cnt + 1;
      if (bready && !(aw_have && w_have)) early_b <= early_b + 1;
      if (bvalid && bready) begin
        aw_have <= 0; w_have <= 0;
        if (aw_a < 40'h40)
          for (int i = 0; i < 4; i++) if (w_s[i]) regs[aw_a[5:2]][8*i +: 8] <= w_d[8*i +: 8];
      end
      if (arvalid && arready) begin ar_have <= 1; ar_a <= araddr; r_cnt <= 0; end
      else if (ar_have && !rvalid) r_cnt <= r_cnt + 1;
      if (rvalid && rready) ar_have <= 0;
    end
  end

  task automatic send_cmd(input logic w, input logic [39:0] a, input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s; cmd_valid = 1;
    while (!cmd_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (!cmd_ready) begin checks++; errors++; $display("FAIL cmd_accept: cmd_ready=0 after %0d cycles, required 1", n); end
    @(posedge clk); #1;
    cmd_valid = 0;
    acc = cyc;
  endtask

  task automatic get_rsp;
    int n = 0;
    while (!rsp_valid && n < 50) begin @(posedge clk); #1; n++; end
    if (!rsp_valid) begin checks++; errors++; $display("FAIL rsp_wait: rsp_valid=0 after %0d cycles, required 1", n); end
    g_rdata = rsp_rdata; g_resp = rsp_resp; g_to = rsp_timeout; g_lat = cyc - acc;
    if (rsp_ready) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if ({cmd_ready, rsp_valid, awvalid, wvalid, bready, arvalid, rready, rsp_timeout} !== 8'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b, required 00000000", {cmd_ready, rsp_valid, awvalid, wvalid, bready, arvalid, rready, rsp_timeout}); end
    checks++; if ({rsp_rdata, rsp_resp} !== 34'h0) begin errors++; $display("FAIL reset_rsp: got %h/%h, required 0/0", rsp_rdata, rsp_resp); end
    checks++; if ({awprot, arprot} !== 6'b0) begin errors++; $display("FAIL prot: got %b, required 000000", {awprot, arprot}); end
    rst_n = 1;
    #1;
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL ready_before_clk: got %b, required 0", cmd_ready); end
    @(posedge clk); #1;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL ready_after_clk: got %b, required 1", cmd_ready); end
  endtask

  task automatic test_write_read;
    send_cmd(1, 40'h08, 32'h0000_0003, 4'hF);
    checks++; if ({awvalid, wvalid, arvalid} !== 3'b110) begin errors++; $display("FAIL wr_valids: got %b, required 110", {awvalid, wvalid, arvalid}); end
    checks++; if (awaddr !== 40'h08 || wdata !== 32'h3 || wstrb !== 4'hF) begin
      errors++; $display("FAIL wr_payload: got %h/%h/%h, required 08/3/f", awaddr, wdata, wstrb); end
    get_rsp;
    checks++; if ({g_rdata, g_resp, g_to} !== 35'h0) begin errors++; $display("FAIL wr_rsp: got %h/%h/%b, required 0/0/0", g_rdata, g_resp, g_to); end
    checks++; if (g_lat !== 2) begin errors++; $display("FAIL wr_latency: got %0d, required 2", g_lat); end
    send_cmd(0, 40'h0B, 32'h0, 4'h0);
    checks++; if (araddr !== 40'h08 || arvalid !== 1'b1) begin errors++; $display("FAIL rd_addr_align: got %h/%b, required 08/1", araddr, arvalid); end
    get_rsp;
    checks++; if (g_rdata !== 32'h3 || g_resp !== 2'b00) begin errors++; $display("FAIL rd_08: got %h/%h, required 00000003/0", g_rdata, g_resp); end
    send_cmd(0, 40'h00, 32'h0, 4'h0);
    get_rsp;
    checks++; if (g_rdata !== 32'hDEADBEEF || g_resp !== 2'b00) begin errors++; $display("FAIL rd_00: got %h/%h, required deadbeef/0", g_rdata, g_resp); end
  endtask

  task automatic test_write_skew;
    int a0 = aw_hs, w0 = w_hs, e0 = early_b;
    aw_delay = 3; w_delay = 0;
    send_cmd(1, 40'h0C, 32'hA5A5_0001, 4'hF);
    @(posedge clk); #1;
    checks++; if ({awvalid, wvalid} !== 2'b10) begin errors++; $display("FAIL aw_slow: got aw,w=%b, required 10", {awvalid, wvalid}); end
    get_rsp;
    checks++; if (g_resp !== 2'b00 || g_to !== 1'b0) begin errors++; $display("FAIL aw_slow_rsp: got %h/%b, required 0/0", g_resp, g_to); end
    aw_delay = 0; w_delay = 3;
    send_cmd(1, 40'h10, 32'hA5A5_0002, 4'hF);
    @(posedge clk); #1;
    checks++; if ({awvalid, wvalid} !== 2'b01) begin errors++; $display("FAIL w_slow: got aw,w=%b, required 01", {awvalid, wvalid}); end
    get_rsp;
    checks++; if (g_resp !== 2'b00) begin errors++; $display("FAIL w_slow_rsp: got %h, required 0", g_resp); end
    aw_delay = 2; w_delay = 2;
    send_cmd(1, 40'h14, 32'h1122_3344, 4'b0101);
    get_rsp;
    checks++; if (g_resp !== 2'b00) begin errors++; $display("FAIL both_rsp: got %h, required 0", g_resp); end
    aw_delay = 0; w_delay = 0;
    checks++; if (aw_hs - a0 !== 3 || w_hs - w0 !== 3) begin errors++; $display("FAIL hs_count: got aw=%0d w=%0d, required 3/3", aw_hs - a0, w_hs - w0); end
    checks++; if (early_b !== e0) begin errors++; $display("FAIL bready_early: got %0d, required %0d", early_b, e0); end
    send_cmd(0, 40'h14, 32'h0, 4'h0);
    get_rsp;
    checks++; if (g_rdata !== 32'h0022_0044) begin errors++; $display("FAIL strobe: got %h, required 00220044", g_rdata); end
  endtask

  task automatic test_read_backpressure;
    r_delay = 5; rsp_ready = 0;
    send_cmd(0, 40'h08, 32'h0, 4'h0);
    get_rsp;
    checks++; if (g_lat !== 7) begin errors++; $display("FAIL rd_delay_latency: got %0d, required 7", g_lat); end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++; if ({rsp_valid, cmd_ready, rsp_timeout} !== 3'b100 || rsp_rdata !== 32'h3) begin
        errors++; $display("FAIL hold_%0d: got v,r,to=%b data=%h, required 100 data=00000003", i, {rsp_valid, cmd_ready, rsp_timeout}, rsp_rdata); end
    end
    rsp_ready = 1;
    @(posedge clk); #1;
    checks++; if ({rsp_valid, cmd_ready} !== 2'b01) begin errors++; $display("FAIL hold_release: got v,r=%b, required 01", {rsp_valid, cmd_ready}); end
    r_delay = 0;
  endtask

  task automatic test_timeout;
    int n = 0;
    ar_en = 0;
    send_cmd(0, 40'h20, 32'h0, 4'h0);
    while (arvalid && n < 40) begin @(posedge clk); #1; n++; end
    checks++; if (n !== 16) begin errors++; $display("FAIL to_arvalid_cycles: got %0d, required 16", n); end
    checks++; if ({rsp_valid, rsp_timeout, rsp_resp} !== 4'b1111 || rsp_rdata !== 32'hDEADDEAD) begin
      errors++; $display("FAIL to_rsp: got v,to,resp=%b data=%h, required 1111 data=deaddead", {rsp_valid, rsp_timeout, rsp_resp}, rsp_rdata); end
    checks++; if ({rready, arvalid} !== 2'b00) begin errors++; $display("FAIL to_bus_idle: got %b, required 00", {rready, arvalid}); end
    @(posedge clk); #1;
    ar_en = 1;
    send_cmd(0, 40'h08, 32'h0, 4'h0);
    get_rsp;
    checks++; if (g_rdata !== 32'h3 || g_resp !== 2'b00 || g_to !== 1'b0) begin
      errors++; $display("FAIL after_to: got %h/%h/%b, required 00000003/0/0", g_rdata, g_resp, g_to); end
  endtask

  task automatic test_reset_mid;
    w_delay = 10;
    send_cmd(1, 40'h18, 32'h5555_AAAA, 4'hF);
    @(posedge clk); #1;
    checks++; if ({awvalid, wvalid} !== 2'b01) begin errors++; $display("FAIL mid_pending: got aw,w=%b, required 01", {awvalid, wvalid}); end
    #2;
    rst_n = 0;
    #1;
    checks++; if ({awvalid, wvalid, rsp_valid, cmd_ready} !== 4'b0) begin
      errors++; $display("FAIL mid_async: got aw,w,v,r=%b, required 0000", {awvalid, wvalid, rsp_valid, cmd_ready}); end
    @(posedge clk); @(posedge clk); #1;
    w_delay = 0;
    rst_n = 1;
    #1;
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL mid_ready_pre: got %b, required 0", cmd_ready); end
    @(posedge clk); #1;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL mid_ready_post: got %b, required 1", cmd_ready); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_no_rsp: got %b, required 0", rsp_valid); end
  endtask

  task automatic test_back_to_back;
    int a0, a1, a2, a3;
    send_cmd(1, 40'h100, 32'h1, 4'hF);
    get_rsp;
    checks++; if (g_resp !== 2'b10 || g_to !== 1'b0 || g_rdata !== 32'h0) begin
      errors++; $display("FAIL slverr: got %h/%b/%h, required 2/0/0", g_resp, g_to, g_rdata); end
    send_cmd(1, 40'h1C, 32'hCAFE_0001, 4'hF); a0 = acc; get_rsp;
    send_cmd(0, 40'h1C, 32'h0, 4'h0);        a1 = acc; get_rsp;
    checks++; if (g_rdata !== 32'hCAFE_0001) begin errors++; $display("FAIL b2b_data: got %h, required cafe0001", g_rdata); end
    send_cmd(1, 40'h20, 32'hCAFE_0002, 4'hF); a2 = acc; get_rsp;
    send_cmd(0, 40'h20, 32'h0, 4'h0);        a3 = acc; get_rsp;
    checks++; if (g_rdata !== 32'hCAFE_0002) begin errors++; $display("FAIL b2b_data2: got %h, required cafe0002", g_rdata); end
    checks++; if (a1 - a0 !== 4 || a2 - a1 !== 4 || a3 - a2 !== 4) begin
      errors++; $display("FAIL b2b_spacing: got %0d,%0d,%0d, required 4,4,4", a1 - a0, a2 - a1, a3 - a2); end
  endtask

  initial begin
    test_reset;
    test_write_read;
    test_write_skew;
    test_read_backpressure;
    test_timeout;
    test_reset_mid;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench still running at %0t, required finish", $time);
    $fatal(1);
  end
endmodule
